// File: rtl/stream_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_pkg
// Brief    : Shared constants and lock-state type for the round-robin stream mux.
// Revision : 1.0 - initial release
// ============================================================================
package stream_mux_pkg;

  localparam int c_def_n = 4;
  localparam int c_def_w = 8;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

endpackage : stream_mux_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; one-hot grant to the first
//            requester at or above ptr, wrapping modulo N.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N = c_def_n
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_hi;
  logic [N-1:0] w_pick;

  for (genvar g = 0; g < N; g++) begin : g_mask
    assign w_mask[g] = (PW'(g) >= ptr);
  end

  // Prefer requesters at or above ptr; fall back to the wrapped-around set.
  assign w_hi   = req & w_mask;
  assign w_pick = (|w_hi) ? w_hi : req;
  assign grant  = w_pick & (~w_pick + N'(1));

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : stream_mux_rr
// Brief    : N-to-1 round-robin stream mux with a single registered output
//            stage. Define STREAM_MUX_PKT_LOCK_EN to hold a grant for a packet.
// Revision : 1.0 - initial release
// ============================================================================
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N = c_def_n,
  parameter int W = c_def_w
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*W-1:0]       in_data,
  input  logic [N-1:0]         in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_sel
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] r_ptr;
  logic          r_run;
  logic [N-1:0]  w_req;
  logic [N-1:0]  w_grant;
  logic          w_load_ok;
  logic          w_accept;
  logic          w_last;
  logic          w_release;
  logic [PW-1:0] w_sel;
  logic [PW-1:0] w_ptr_next;
  logic [W-1:0]  w_data_or [N+1];
  logic [PW-1:0] w_sel_or  [N+1];

  rr_arbiter #(.N(N)) u_arb (
    .req   (w_req),
    .ptr   (r_ptr),
    .grant (w_grant)
  );

  // r_run keeps in_ready low while reset is asserted without a rst_n->output path.
  assign w_load_ok = ~out_valid | out_ready;
  assign in_ready  = w_grant & in_valid & {N{w_load_ok & r_run}};
  assign w_accept  = |in_ready;
  assign w_last    = |(in_ready & in_last);

  assign w_data_or[0] = '0;
  assign w_sel_or[0]  = '0;
  for (genvar g = 0; g < N; g++) begin : g_chan
    assign w_data_or[g+1] = w_data_or[g] | (in_ready[g] ? in_data[g*W +: W] : '0);
    assign w_sel_or[g+1]  = w_sel_or[g]  | (in_ready[g] ? PW'(g) : '0);
  end
  assign w_sel      = w_sel_or[N];
  assign w_ptr_next = (w_sel == PW'(N-1)) ? '0 : w_sel + PW'(1);

`ifdef STREAM_MUX_PKT_LOCK_EN
  lock_state_t   r_state;
  lock_state_t   w_state_next;
  logic [PW-1:0] r_lock_ch;
  logic [N-1:0]  w_lock_mask;

  for (genvar g = 0; g < N; g++) begin : g_lock_mask
    assign w_lock_mask[g] = (r_lock_ch == PW'(g));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lock_ch <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == IDLE && w_accept && !w_last) begin
        r_lock_ch <= w_sel;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:   if (w_accept && !w_last) w_state_next = LOCKED;
      LOCKED: if (w_accept &&  w_last) w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_req = in_valid;
    if (r_state == LOCKED) begin
      w_req = in_valid & w_lock_mask;
    end
  end

  assign w_release = w_accept & w_last;
`else
  assign w_req     = in_valid;
  assign w_release = w_accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      r_ptr <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_release) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= '0;
    end else if (w_load_ok) begin
      out_valid <= w_accept;
      if (w_accept) begin
        out_data <= w_data_or[N];
        out_last <= w_last;
        out_sel  <= w_sel;
      end
    end
  end

endmodule : stream_mux_rr
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_mux_rr
// Brief    : Directed scoreboard bench for stream_mux_rr (N=4, W=8); honours
//            STREAM_MUX_PKT_LOCK_EN for the packet-lock expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_sel;

  int errors = 0;
  int checks = 0;

  beat_t        sb[$];
  int           rem  [N];
  int           seq  [N];
  int           plen [N];
  logic [W-1:0] base [N];
  logic [N-1:0] acc;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input int sel, input int data, input bit last);
    beat_t b;
    b.sel  = SW'(sel);
    b.data = W'(data);
    b.last = last;
    sb.push_back(b);
  endtask

  task automatic clr_src();
    for (int c = 0; c < N; c++) begin
      rem[c]  = 0;
      seq[c]  = 0;
      plen[c] = 1;
      base[c] = W'(c * 16);
    end
  endtask

  task automatic drive();
    for (int c = 0; c < N; c++) begin
      in_valid[c]        = (rem[c] > 0);
      in_data[c*W +: W]  = base[c] + W'(seq[c]);
      in_last[c]         = ((seq[c] % plen[c]) == plen[c] - 1);
    end
  endtask

  // Observe the handshake away from the edge, then advance the sources.
  task automatic sync();
    @(negedge clk);
    acc = in_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (acc[c]) begin
        seq[c]++;
        rem[c]--;
      end
    end
    acc = '0;
    drive();
  endtask

  task automatic step();
    sync();
    advance();
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Scoreboard: every beat leaving the mux must match the next expected beat.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $error("FAIL unexpected_beat observed sel=%0d data=%h last=%0d expected none",
               out_sel, out_data, out_last);
      end else begin
        beat_t e;
        e = sb.pop_front();
        assert ({out_sel, out_data, out_last} === e) else begin
          errors++;
          $error("FAIL out_beat observed sel=%0d data=%h last=%0d expected sel=%0d data=%h last=%0d",
                 out_sel, out_data, out_last, e.sel, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    acc       = '0;
    clr_src();
    drive();
    repeat (2) @(posedge clk);
    #1;

    sync();
    chk("reset_state", {17'd0, out_valid, out_last, out_sel, out_data, in_ready}, 32'd0);
    advance();
    rst_n = 1'b1;

    for (int k = 0; k < 10; k++) begin
      sync();
      chk("idle_after_reset", {25'd0, out_valid, out_sel, in_ready}, 32'd0);
      advance();
    end

    // Round robin with every channel valid: 0,1,2,3,0,1,2,3 back to back.
    for (int c = 0; c < N; c++) rem[c] = 2;
    drive();
    for (int k = 0; k < 8; k++) push(k % 4, (k % 4) * 16 + k / 4, 1'b1);
    for (int k = 0; k < 8; k++) begin
      sync();
      chk("rr_grant", {28'd0, in_ready}, 32'd1 << (k % 4));
      if (k > 0) chk("rr_throughput", {31'd0, out_valid}, 32'd1);
      advance();
    end
    wait_drain("rr");

    // Backpressure on channel 2, then drain and reload in the same cycle.
    clr_src();
    base[2]   = 8'hA5;
    rem[2]    = 2;
    out_ready = 1'b0;
    drive();
    push(2, 8'hA5, 1'b1);
    push(2, 8'hA6, 1'b1);
    sync();
    chk("stall_first_accept", {28'd0, in_ready}, 32'b0100);
    advance();
    for (int k = 0; k < 3; k++) begin
      sync();
      chk("stall_hold", {17'd0, out_valid, out_sel, out_data, in_ready},
          {17'd0, 1'b1, 2'd2, 8'hA5, 4'b0000});
      advance();
    end
    out_ready = 1'b1;
    sync();
    chk("drain_and_load", {28'd0, in_ready}, 32'b0100);
    advance();
    sync();
    chk("no_bubble", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'hA6});
    advance();
    wait_drain("stall");

    // Single beat from channel 0 leaves ptr at 1.
    clr_src();
    rem[0] = 1;
    drive();
    push(0, 8'h00, 1'b1);
    wait_drain("pre_beat");

    // Channel 1 sends a 3-beat packet while channel 0 stays valid.
    clr_src();
    rem[0]  = 2;
    rem[1]  = 3;
    plen[1] = 3;
    drive();
`ifdef STREAM_MUX_PKT_LOCK_EN
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    push(0, 8'h00, 1'b1);
    push(0, 8'h01, 1'b1);
`else
    push(1, 8'h10, 1'b0);
    push(0, 8'h00, 1'b1);
    push(1, 8'h11, 1'b0);
    push(0, 8'h01, 1'b1);
    push(1, 8'h12, 1'b1);
`endif
    wait_drain("packet");

    // Reset in the middle of a channel-3 packet.
    clr_src();
    rem[3]    = 3;
    plen[3]   = 3;
    out_ready = 1'b0;
    drive();
    sync();
    chk("ch3_first_grant", {28'd0, in_ready}, 32'b1000);
    advance();
    step();
    rst_n = 1'b0;
    #1;
    chk("reset_async", {27'd0, out_valid, in_ready}, 32'd0);
    sync();
    chk("reset_hold", {17'd0, out_valid, out_last, out_sel, out_data, in_ready}, 32'd0);
    advance();
    rst_n = 1'b1;
    clr_src();
    rem[0]    = 1;
    rem[3]    = 1;
    out_ready = 1'b1;
    drive();
    push(0, 8'h00, 1'b1);
    push(3, 8'h30, 1'b1);
    step();
    sync();
    chk("post_reset_grant", {28'd0, in_ready}, 32'b0001);
    advance();
    wait_drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_stream_mux_rr
`default_nettype wire

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 Parameter N, default 4, number of input channels; SHALL be >= 2.
REQ-002 Parameter W, default 8, data width per channel in bits; SHALL be >= 1.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1; reset SHALL be asynchronous and active-low.
REQ-005 Port in_valid, input, N; bit i set means channel i offers a beat.
REQ-006 Port in_ready, output, N; bit i set means channel i's beat is accepted this cycle.
REQ-007 Port in_data, input, N*W; channel i occupies bits [i*W +: W].
REQ-008 Port in_last, input, N; bit i marks the final beat of a packet on channel i.
REQ-009 Port out_valid, output, 1; set means the output register holds a beat.
REQ-010 Port out_ready, input, 1; set means the sink accepts the output beat.
REQ-011 Port out_data, output, W; registered data of the held beat.
REQ-012 Port out_last, output, 1; registered last flag of the held beat.
REQ-013 Port out_sel, output, $clog2(N); registered source channel index of the held beat.

Function
REQ-014 A transfer SHALL occur on a port when valid and ready are both high at a rising clk edge.
REQ-015 The output stage SHALL be a single register; it can load when out_valid=0 or out_ready=1.
REQ-016 At most one in_ready bit SHALL be high per cycle; in_ready[g] = grant[g] AND in_valid[g] AND load-allowed.
REQ-017 in_ready MAY depend combinationally on out_ready and in_valid; no other input-to-output combinational path SHALL exist.
REQ-018 Latency: a beat accepted at edge k SHALL appear on out_data/out_last/out_sel with out_valid=1 after edge k.
REQ-019 Sustained throughput SHALL be one beat per cycle when out_ready is held high.
REQ-020 When unlocked, the grant SHALL go to the first channel with in_valid=1, searching from pointer ptr upward, modulo N.
REQ-021 After a beat from channel g is accepted and arbitration is released, ptr SHALL become (g+1) mod N.
REQ-022 Without any in_valid, grant and ptr SHALL be unchanged, and out_valid SHALL clear once the held beat drains.
REQ-023 When out_valid=1 and out_ready=0, all output registers SHALL hold and all in_ready bits SHALL be 0.
REQ-024 A simultaneous drain and load in one cycle SHALL replace the held beat with no bubble.
REQ-025 When N is not a power of two, out_sel SHALL never exceed N-1 and ptr SHALL wrap from N-1 to 0.

Reset
REQ-026 While rst_n=0: out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, lock state IDLE, and in_ready=0.
REQ-027 Reset asserted mid-packet SHALL discard the held beat and the lock; the first grant after release SHALL start the search from channel 0.

Configuration
REQ-028 Macro STREAM_MUX_PKT_LOCK_EN SHALL select the packet-lock feature.
REQ-029 With the macro defined, the FSM SHALL have two states, IDLE and LOCKED.
REQ-030 IDLE to LOCKED SHALL occur on an accepted beat with in_last=0, latching that channel.
REQ-031 LOCKED to IDLE SHALL occur on an accepted beat from the latched channel with in_last=1.
REQ-032 In LOCKED, only the latched channel SHALL be granted, regardless of other channels.
REQ-033 In LOCKED, ptr SHALL update only on the transition to IDLE.
REQ-034 With the macro undefined, arbitration SHALL be released after every accepted beat; in_last SHALL only pass through to out_last.

Structure
REQ-035 Package stream_mux_pkg SHALL hold the default N and W constants and the lock-state enumerated type (IDLE, LOCKED).
REQ-036 Sub-module rr_arbiter SHALL compute a one-hot grant from the request vector and ptr; it SHALL be purely combinational.
REQ-037 stream_mux_rr SHALL own ptr, the lock FSM, and the output register.

Verification
REQ-038 Reset release, no traffic -> out_valid=0, out_sel=0, in_ready=0000 for 10 cycles.
REQ-039 N=4, all in_valid=1, all in_last=1, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, one beat per cycle.
REQ-040 Channel 2 sends data 0xA5; out_ready=0 for 3 cycles -> out_data=0xA5 and out_sel=2 held stable; in_ready=0000 until out_ready=1.
REQ-041 With STREAM_MUX_PKT_LOCK_EN, channel 1 sends a 3-beat packet while channel 0 stays valid -> out_sel=1,1,1, then 0.
REQ-042 Without STREAM_MUX_PKT_LOCK_EN, the same stimulus -> out_sel interleaves 1,0,1,0,1.
REQ-043 rst_n pulsed low mid-packet (locked on channel 3) -> out_valid=0 immediately; after release with channels 0 and 3 valid, channel 0 is granted first.
